alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 clears state immediately, independent of clk.
REQ-003 rdy  input  1  global enable; rdy=0 freezes all state and holds all outputs.
REQ-004 rollback  input  1  misprediction flush from ROB.
REQ-005 alu_en  input  1  operation valid from reservation station, one op per cycle, no backpressure.
REQ-006 alu_val1, alu_val2, alu_imm, alu_pc  input  32 each  rs1 value, rs2 value, sign-extended immediate, instruction PC.
REQ-007 alu_opcode  input  7  RV32I major opcode.
REQ-008 alu_funct3  input  3  funct3 field.
REQ-009 alu_funct7  input  1  instruction bit 30.
REQ-010 alu_rob_pos  input  4  destination ROB slot.
REQ-011 alu_result  output  1  result-valid broadcast to RS, LSB and ROB.
REQ-012 alu_result_val  output  32  rd write value.
REQ-013 alu_result_rob_pos  output  4  ROB slot of result.
REQ-014 alu_result_jump  output  1  control transfer taken.
REQ-015 alu_result_pc  output  32  resolved next PC.

Function
REQ-016 Two-stage pipeline: S1 captures inputs and computes value/branch outcome; S2 registers result onto outputs; alu_en at edge N -> alu_result=1 after edge N+1 (latency 2 edges), throughput 1 op/cycle.
REQ-017 Each stage carries a valid bit; alu_result equals S2 valid; bubbles propagate as alu_result=0.
REQ-018 OP (0110011): funct3 000 ADD/SUB (SUB when funct7=1), 001 SLL, 010 SLT signed, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA when funct7=1), 110 OR, 111 AND; operand2 = alu_val2; shift amount = alu_val2[4:0].
REQ-019 OP-IMM (0010011): same table with operand2 = alu_imm; funct7 ignored except funct3=101 (SRAI when funct7=1); no SUBI; shift amount = alu_imm[4:0].
REQ-020 LUI (0110111): value = alu_imm; AUIPC (0010111): value = alu_pc + alu_imm (mod 2^32).
REQ-021 JAL (1101111): value = alu_pc+4, jump=1, next PC = alu_pc+alu_imm.
REQ-022 JALR (1100111): value = alu_pc+4, jump=1, next PC = (alu_val1+alu_imm) with bit 0 cleared.
REQ-023 BRANCH (1100011): funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU on alu_val1/alu_val2; jump=taken; next PC = taken ? alu_pc+alu_imm : alu_pc+4; value = 0.
REQ-024 Non-control ops: jump=0, next PC = alu_pc+4.
REQ-025 Unlisted opcode or funct3 with alu_en=1: op still completes, value=0, jump=0, next PC = alu_pc+4.
REQ-026 All arithmetic 32-bit, wraps modulo 2^32, no overflow flag.
REQ-027 Rollback=1 at an edge with rdy=1: both valid bits cleared, alu_en that same cycle discarded; alu_result=0 after that edge; datapath registers may keep stale values.
REQ-028 rdy=0: all registers, including valids, hold; alu_en in that cycle ignored; alu_result keeps its level (consumers gate on rdy).
REQ-029 rdy=0 and rollback=1 together: rdy wins, nothing changes.
REQ-030 alu_en=1 with alu_result=1 same cycle: both proceed; no stall path.

Reset
REQ-031 rst=0: S1/S2 valid=0, alu_result=0, alu_result_val=0, alu_result_rob_pos=0, alu_result_jump=0, alu_result_pc=0, asynchronously.
REQ-032 Reset mid-operation drops all in-flight ops; first alu_en accepted at first rising edge with rst=1 and rdy=1.

Verification
REQ-033 ADD val1=5, val2=0xFFFFFFFF, rob_pos=3 -> two edges later alu_result=1, val=4, rob_pos=3, jump=0, pc=pc+4.
REQ-034 BLT val1=0xFFFFFFFE, val2=1, pc=0x100, imm=0x20 -> jump=1, pc=0x120; same as BLTU -> jump=0, pc=0x104.
REQ-035 JALR pc=0x40, val1=0x1001, imm=2 -> val=0x44, jump=1, pc=0x1002.
REQ-036 Back-to-back SRAI imm=0x404 on 0x80000000 then SRLI imm=4 -> consecutive cycles val=0xF8000000 then 0x08000000.
REQ-037 Ops issued on cycles N, N+1, rollback on N+1 -> neither produces alu_result; op on N+2 completes normally.
REQ-038 rdy=0 for 3 cycles with op in S1 -> output appears only after rdy returns; rst=0 pulse mid-flight -> all outputs 0 immediately, no later result.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Issue/result bundle between the reservation station and the ALU pipe.
// master drives the operation, slave returns the broadcast result.
interface alu_pipe_if;
   logic        alu_en;
   logic [31:0] alu_val1;
   logic [31:0] alu_val2;
   logic [31:0] alu_imm;
   logic [31:0] alu_pc;
   logic [6:0]  alu_opcode;
   logic [2:0]  alu_funct3;
   logic        alu_funct7;
   logic [3:0]  alu_rob_pos;
   logic        alu_result;
   logic [31:0] alu_result_val;
   logic [3:0]  alu_result_rob_pos;
   logic        alu_result_jump;
   logic [31:0] alu_result_pc;

   modport master (
      output alu_en, alu_val1, alu_val2, alu_imm, alu_pc,
      output alu_opcode, alu_funct3, alu_funct7, alu_rob_pos,
      input  alu_result, alu_result_val, alu_result_rob_pos,
      input  alu_result_jump, alu_result_pc
   );

   modport slave (
      input  alu_en, alu_val1, alu_val2, alu_imm, alu_pc,
      input  alu_opcode, alu_funct3, alu_funct7, alu_rob_pos,
      output alu_result, alu_result_val, alu_result_rob_pos,
      output alu_result_jump, alu_result_pc
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage RV32I integer ALU: S1 latches the op, S2 holds the result.
// rdy freezes everything; rollback flushes both stages.
module alu_pipe (
   input  logic     clk,
   input  logic     rst,
   input  logic     rdy,
   input  logic     rollback,
   alu_pipe_if.slave io
);
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JLR = 7'b1100111;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [3:0]  rob;
   } s1_t;

   typedef struct packed {
      logic [31:0] val;
      logic [3:0]  rob;
      logic        jump;
      logic [31:0] pc;
   } s2_t;

   logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   s1_t  s1_q, s1_d;
   s2_t  s2_q, s2_d;
   s2_t  res;

   logic [31:0] op2, alu_out, pc4, tgt;
   logic [4:0]  sh;
   logic        taken;

   always_comb begin
      op2 = (s1_q.op == OP_R) ? s1_q.v2 : s1_q.imm;
      sh  = op2[4:0];
      pc4 = s1_q.pc + 32'd4;
      tgt = s1_q.pc + s1_q.imm;
      alu_out = '0;
      case (s1_q.f3)
         3'b000: alu_out = (s1_q.op == OP_R && s1_q.f7)
                         ? s1_q.v1 - op2 : s1_q.v1 + op2;
         3'b001: alu_out = s1_q.v1 << sh;
         3'b010: alu_out = {31'b0, $signed(s1_q.v1) < $signed(op2)};
         3'b011: alu_out = {31'b0, s1_q.v1 < op2};
         3'b100: alu_out = s1_q.v1 ^ op2;
         3'b101: alu_out = s1_q.f7
                         ? $unsigned($signed(s1_q.v1) >>> sh)
                         : s1_q.v1 >> sh;
         3'b110: alu_out = s1_q.v1 | op2;
         default: alu_out = s1_q.v1 & op2;
      endcase
      taken = 1'b0;
      case (s1_q.f3)
         3'b000: taken = s1_q.v1 == s1_q.v2;
         3'b001: taken = s1_q.v1 != s1_q.v2;
         3'b100: taken = $signed(s1_q.v1) < $signed(s1_q.v2);
         3'b101: taken = $signed(s1_q.v1) >= $signed(s1_q.v2);
         3'b110: taken = s1_q.v1 < s1_q.v2;
         3'b111: taken = s1_q.v1 >= s1_q.v2;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      res.val  = '0;
      res.rob  = s1_q.rob;
      res.jump = 1'b0;
      res.pc   = pc4;
      case (s1_q.op)
         OP_R, OP_I: res.val = alu_out;
         OP_LUI: res.val = s1_q.imm;
         OP_AUI: res.val = tgt;
         OP_JAL: begin
            res.val  = pc4;
            res.jump = 1'b1;
            res.pc   = tgt;
         end
         OP_JLR: begin
            res.val  = pc4;
            res.jump = 1'b1;
            res.pc   = (s1_q.v1 + s1_q.imm) & ~32'd1;
         end
         OP_BR: begin
            res.jump = taken;
            res.pc   = taken ? tgt : pc4;
         end
         default: res.val = '0;
      endcase
   end

   always_comb begin
      s1_v_d = s1_v_q;
      s2_v_d = s2_v_q;
      s1_d   = s1_q;
      s2_d   = s2_q;
      if (rdy) begin
         s1_d = '{op: io.alu_opcode, f3: io.alu_funct3,
                  f7: io.alu_funct7, v1: io.alu_val1,
                  v2: io.alu_val2, imm: io.alu_imm,
                  pc: io.alu_pc, rob: io.alu_rob_pos};
         s2_d = res;
         // A flush kills the op now entering S2 and the one arriving
         s1_v_d = rollback ? 1'b0 : io.alu_en;
         s2_v_d = rollback ? 1'b0 : s1_v_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         s1_q   <= '0;
         s2_q   <= '0;
      end else begin
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         s1_q   <= s1_d;
         s2_q   <= s2_d;
      end
   end

   assign io.alu_result         = s2_v_q;
   assign io.alu_result_val     = s2_q.val;
   assign io.alu_result_rob_pos = s2_q.rob;
   assign io.alu_result_jump    = s2_q.jump;
   assign io.alu_result_pc      = s2_q.pc;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: stimulus queues expected results,
// a monitor checks every accepted edge against the queue head.
module tb_alu_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy, rollback;

   alu_pipe_if io ();

   alu_pipe dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .rollback (rollback),
      .io       (io)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] val;
      logic [3:0]  rob;
      logic        jump;
      logic [31:0] pc;
   } exp_t;

   exp_t q[$];
   int   acc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) if (rst && rdy) acc <= acc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: plain RV32I semantics
   function automatic exp_t model(input logic [6:0] op,
         input logic [2:0] f3, input logic f7,
         input logic [31:0] v1, input logic [31:0] v2,
         input logic [31:0] imm, input logic [31:0] pc);
      exp_t e;
      logic [31:0] b;
      logic [63:0] ext;
      int sh;
      logic t;
      e.due = 0; e.rob = '0;
      e.val = 0; e.jump = 0; e.pc = pc + 4;
      case (op)
         7'h33, 7'h13: begin
            b = (op == 7'h33) ? v2 : imm;
            sh = int'(b[4:0]);
            case (f3)
               3'd0: e.val = (op == 7'h33 && f7) ? v1 + (~b + 1) : v1 + b;
               3'd1: e.val = v1 * (32'd1 << sh);
               3'd2: e.val = (int'(v1) < int'(b)) ? 32'd1 : 32'd0;
               3'd3: e.val = (v1 < b) ? 32'd1 : 32'd0;
               3'd4: e.val = v1 ^ b;
               3'd5: begin
                  ext = f7 ? {{32{v1[31]}}, v1} : {32'b0, v1};
                  ext = ext >> sh;
                  e.val = ext[31:0];
               end
               3'd6: e.val = v1 | b;
               default: e.val = v1 & b;
            endcase
         end
         7'h37: e.val = imm;
         7'h17: e.val = pc + imm;
         7'h6F: begin e.val = pc + 4; e.jump = 1; e.pc = pc + imm; end
         7'h67: begin
            e.val = pc + 4; e.jump = 1;
            e.pc = (v1 + imm) & 32'hFFFF_FFFE;
         end
         7'h63: begin
            case (f3)
               3'd0: t = (v1 == v2);
               3'd1: t = (v1 != v2);
               3'd4: t = (int'(v1) < int'(v2));
               3'd5: t = !(int'(v1) < int'(v2));
               3'd6: t = (v1 < v2);
               3'd7: t = !(v1 < v2);
               default: t = 0;
            endcase
            if (t) begin e.jump = 1; e.pc = pc + imm; end
         end
         default: ;
      endcase
      return e;
   endfunction

   // Drive one cycle at negedge; book-keep what the next edge will do
   task automatic drive(input logic en, input logic [6:0] op,
         input logic [2:0] f3, input logic f7,
         input logic [31:0] v1, input logic [31:0] v2,
         input logic [31:0] imm, input logic [31:0] pc,
         input logic [3:0] rob, input logic r, input logic rb,
         input logic use_exp, input logic [31:0] ev,
         input logic ej, input logic [31:0] epc);
      exp_t e;
      @(negedge clk);
      rdy = r; rollback = rb;
      io.alu_en = en; io.alu_opcode = op; io.alu_funct3 = f3;
      io.alu_funct7 = f7; io.alu_val1 = v1; io.alu_val2 = v2;
      io.alu_imm = imm; io.alu_pc = pc; io.alu_rob_pos = rob;
      if (rst && r) begin
         if (rb) begin
            while (q.size() > 0 && q[$].due == acc + 1) void'(q.pop_back());
         end else if (en) begin
            e = model(op, f3, f7, v1, v2, imm, pc);
            if (use_exp) begin e.val = ev; e.jump = ej; e.pc = epc; end
            e.rob = rob;
            e.due = acc + 2;
            q.push_back(e);
         end
      end
   endtask

   task automatic idle(input logic r);
      drive(0, 7'h0, 3'd0, 0, 0, 0, 0, 0, 4'd0, r, 0, 0, 0, 0, 0);
   endtask

   task automatic dir(input logic [6:0] op, input logic [2:0] f3,
         input logic f7, input logic [31:0] v1, input logic [31:0] v2,
         input logic [31:0] imm, input logic [31:0] pc,
         input logic [3:0] rob, input logic rb, input logic [31:0] ev,
         input logic ej, input logic [31:0] epc);
      drive(1, op, f3, f7, v1, v2, imm, pc, rob, 1, rb, 1, ev, ej, epc);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_result"}, {31'b0, io.alu_result}, 0);
      chk({tag, "_val"}, io.alu_result_val, 0);
      chk({tag, "_rob"}, {28'b0, io.alu_result_rob_pos}, 0);
      chk({tag, "_jump"}, {31'b0, io.alu_result_jump}, 0);
      chk({tag, "_pc"}, io.alu_result_pc, 0);
   endtask

   // Monitor
   initial begin
      logic r;
      logic [31:0] pv, ppc;
      logic [3:0]  prob;
      logic        pres, pj;
      exp_t e;
      pv = 0; ppc = 0; prob = 0; pres = 0; pj = 0;
      forever begin
         @(posedge clk);
         r = rdy;
         #1;
         if (!rst) begin
            chk_zero("mon_rst");
         end else if (!r) begin
            chk("hold_result", {31'b0, io.alu_result}, {31'b0, pres});
            chk("hold_val", io.alu_result_val, pv);
            chk("hold_rob", {28'b0, io.alu_result_rob_pos}, {28'b0, prob});
            chk("hold_jump", {31'b0, io.alu_result_jump}, {31'b0, pj});
            chk("hold_pc", io.alu_result_pc, ppc);
         end else if (q.size() > 0 && q[0].due == acc) begin
            e = q.pop_front();
            chk("result", {31'b0, io.alu_result}, 1);
            chk("val", io.alu_result_val, e.val);
            chk("rob", {28'b0, io.alu_result_rob_pos}, {28'b0, e.rob});
            chk("jump", {31'b0, io.alu_result_jump}, {31'b0, e.jump});
            chk("pc", io.alu_result_pc, e.pc);
         end else begin
            chk("bubble", {31'b0, io.alu_result}, 0);
         end
         pres = io.alu_result; pv = io.alu_result_val;
         prob = io.alu_result_rob_pos; pj = io.alu_result_jump;
         ppc = io.alu_result_pc;
      end
   end

   logic [6:0] ops [9];

   initial begin
      logic [31:0] v1, v2;
      logic [6:0]  op;
      ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
              7'h67, 7'h63, 7'h63, 7'h03};
      rdy = 1; rollback = 0;
      io.alu_en = 0; io.alu_opcode = 0; io.alu_funct3 = 0;
      io.alu_funct7 = 0; io.alu_val1 = 0; io.alu_val2 = 0;
      io.alu_imm = 0; io.alu_pc = 0; io.alu_rob_pos = 0;
      rst = 1'b0;
      #1;
      chk_zero("reset");
      @(negedge clk); @(negedge clk);
      rst = 1'b1;

      dir(7'h33, 3'd0, 0, 5, 32'hFFFF_FFFF, 0, 32'h200, 4'd3, 0,
          32'd4, 0, 32'h204);
      dir(7'h63, 3'd4, 0, 32'hFFFF_FFFE, 1, 32'h20, 32'h100, 4'd4, 0,
          0, 1, 32'h120);
      dir(7'h63, 3'd6, 0, 32'hFFFF_FFFE, 1, 32'h20, 32'h100, 4'd5, 0,
          0, 0, 32'h104);
      dir(7'h67, 3'd0, 0, 32'h1001, 0, 2, 32'h40, 4'd6, 0,
          32'h44, 1, 32'h1002);
      dir(7'h13, 3'd5, 1, 32'h8000_0000, 0, 32'h404, 0, 4'd7, 0,
          32'hF800_0000, 0, 4);
      dir(7'h13, 3'd5, 0, 32'h8000_0000, 0, 4, 0, 4'd8, 0,
          32'h0800_0000, 0, 4);
      dir(7'h33, 3'd0, 1, 3, 5, 0, 32'hFFFF_FFFC, 4'd9, 0,
          32'hFFFF_FFFE, 0, 0);
      dir(7'h7F, 3'd0, 0, 3, 5, 0, 32'h10, 4'd10, 0, 0, 0, 32'h14);
      idle(1); idle(1);

      dir(7'h37, 3'd0, 0, 0, 0, 32'h1234_5000, 0, 4'd1, 0,
          32'h1234_5000, 0, 4);
      dir(7'h37, 3'd0, 0, 0, 0, 32'h1, 0, 4'd2, 1, 0, 0, 0);
      dir(7'h17, 3'd0, 0, 0, 0, 32'h10, 32'h80, 4'd11, 0,
          32'h90, 0, 32'h84);
      idle(1); idle(1); idle(1);

      dir(7'h33, 3'd4, 0, 32'hF0F0_0000, 32'h0FF0_0001, 0, 32'h300,
          4'd12, 0, 32'hFF00_0001, 0, 32'h304);
      idle(0); idle(0); idle(0);
      idle(1); idle(1); idle(1);

      dir(7'h6F, 3'd0, 0, 0, 0, 32'h100, 32'h500, 4'd13, 0,
          32'h504, 1, 32'h600);
      dir(7'h33, 3'd7, 0, 32'hFF, 32'h0F, 0, 32'h504, 4'd14, 0,
          32'h0F, 0, 32'h508);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk_zero("async_rst");
      q.delete();
      @(negedge clk);
      io.alu_en = 0;
      rst = 1'b1;
      idle(1); idle(1); idle(1);

      for (int i = 0; i < 600; i++) begin
         op = ops[$urandom_range(0, 8)];
         if ($urandom_range(0, 15) == 0) op = 7'($urandom);
         v1 = $urandom;
         v2 = ($urandom_range(0, 3) == 0) ? v1 : $urandom;
         drive($urandom_range(0, 9) < 7, op, 3'($urandom),
               1'($urandom), v1, v2, $urandom, $urandom,
               4'($urandom), $urandom_range(0, 9) != 0,
               $urandom_range(0, 19) == 0, 0, 0, 0, 0);
      end
      for (int i = 0; i < 4; i++) idle(1);
      @(posedge clk); #2;
      chk("drain", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
